// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with burst line fill/evict over a SysReady-handshaked bus.
// Hit latency 1 cycle after PStrobe is sampled; a miss completes one cycle after the final refill beat; beats stall while SysReady=0.
module dcache_wb #(
    parameter int IDX        = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PStrobe,
    input  logic        PRw,
    input  logic [31:0] PAddress,
    output logic        PReady,
    output logic [31:0] PData_in,
    input  logic [31:0] PData_out,
    output logic        SysStrobe,
    output logic        SysRW,
    output logic [31:0] SysAddress,
    output logic [31:0] SysData_in,
    input  logic [31:0] SysData_out,
    input  logic        SysReady
);
    localparam int OFS   = $clog2(LINE_WORDS);
    localparam int TAG   = 30 - IDX - OFS;
    localparam int OW    = (OFS > 0) ? OFS : 1;
    localparam int LINES = 1 << IDX;

    typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, REFILL, RESPOND} state_t;

    state_t          state_q;
    logic            rw_q, hit_q;
    logic [TAG-1:0]  tag_q;
    logic [IDX-1:0]  idx_q;
    logic [OW-1:0]   off_q, beat_q;
    logic [31:0]     wdata_q;
    logic            pready_q, sys_stb_q, sys_rw_q;
    logic [31:0]     pdata_q, sys_addr_q, sys_wdata_q;
    logic            valid_q [LINES];
    logic            dirty_q [LINES];
    logic [TAG-1:0]  tag_mem [LINES];
    logic [31:0]     data_mem [LINES][LINE_WORDS];

    logic [TAG-1:0]  p_tag;
    logic [IDX-1:0]  p_idx;
    logic [OW-1:0]   p_off, beat_nx;
    logic            p_hit, last, sys_done;
    logic            unused_addr_lsb;

    assign p_tag = PAddress[31:OFS+IDX+2];
    assign p_idx = PAddress[OFS+IDX+1:OFS+2];
    generate
        if (OFS > 0) begin : g_off
            assign p_off = PAddress[OFS+1:2];
        end else begin : g_no_off
            assign p_off = '0;
        end
    endgenerate
    assign unused_addr_lsb = ^PAddress[1:0];

    // Tag compare happens in IDLE so PReady/PData_in can be registered and still land in LOOKUP.
    assign p_hit    = valid_q[p_idx] && (tag_mem[p_idx] == p_tag);
    assign last     = (beat_q == OW'(LINE_WORDS - 1));
    assign beat_nx  = beat_q + 1'b1;
    assign sys_done = sys_stb_q && SysReady;

    function automatic logic [31:0] beat_addr(input logic [TAG-1:0] t, input logic [IDX-1:0] i,
                                              input logic [OW-1:0] b);
        return (32'(t) << (IDX + OFS + 2)) | (32'(i) << (OFS + 2)) | (32'(b) << 2);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rw_q        <= 1'b1;
            hit_q       <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            beat_q      <= '0;
            wdata_q     <= '0;
            pready_q    <= 1'b0;
            pdata_q     <= '0;
            sys_stb_q   <= 1'b0;
            sys_rw_q    <= 1'b1;
            sys_addr_q  <= '0;
            sys_wdata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            pready_q <= 1'b0;
            case (state_q)
                IDLE: if (PStrobe) begin
                    rw_q     <= PRw;
                    tag_q    <= p_tag;
                    idx_q    <= p_idx;
                    off_q    <= p_off;
                    wdata_q  <= PData_out;
                    hit_q    <= p_hit;
                    pready_q <= p_hit;
                    if (p_hit && PRw) pdata_q <= data_mem[p_idx][p_off];
                    state_q  <= LOOKUP;
                end
                LOOKUP: begin
                    if (hit_q) begin
                        if (!rw_q) dirty_q[idx_q] <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        beat_q    <= '0;
                        sys_stb_q <= 1'b1;
                        if (valid_q[idx_q] && dirty_q[idx_q]) begin
                            sys_rw_q    <= 1'b0;
                            sys_addr_q  <= beat_addr(tag_mem[idx_q], idx_q, '0);
                            sys_wdata_q <= data_mem[idx_q][0];
                            state_q     <= WBACK;
                        end else begin
                            sys_rw_q   <= 1'b1;
                            sys_addr_q <= beat_addr(tag_q, idx_q, '0);
                            state_q    <= REFILL;
                        end
                    end
                end
                WBACK: if (sys_done) begin
                    if (last) begin
                        beat_q     <= '0;
                        sys_rw_q   <= 1'b1;
                        sys_addr_q <= beat_addr(tag_q, idx_q, '0);
                        state_q    <= REFILL;
                    end else begin
                        beat_q      <= beat_nx;
                        sys_addr_q  <= beat_addr(tag_mem[idx_q], idx_q, beat_nx);
                        sys_wdata_q <= data_mem[idx_q][beat_nx];
                    end
                end
                REFILL: if (sys_done) begin
                    if (rw_q && beat_q == off_q) pdata_q <= SysData_out;
                    if (last) begin
                        sys_stb_q      <= 1'b0;
                        valid_q[idx_q] <= 1'b1;
                        dirty_q[idx_q] <= !rw_q;
                        pready_q       <= 1'b1;
                        state_q        <= RESPOND;
                    end else begin
                        beat_q     <= beat_nx;
                        sys_addr_q <= beat_addr(tag_q, idx_q, beat_nx);
                    end
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage; the write-miss merge is ordered after the refill beat so it wins on the same word.
    always_ff @(posedge clock) begin
        if (state_q == LOOKUP && hit_q && !rw_q) data_mem[idx_q][off_q] <= wdata_q;
        if (state_q == REFILL && sys_done) begin
            data_mem[idx_q][beat_q] <= SysData_out;
            if (last) begin
                tag_mem[idx_q] <= tag_q;
                if (!rw_q) data_mem[idx_q][off_q] <= wdata_q;
            end
        end
    end

    assign PReady     = pready_q;
    assign PData_in   = pdata_q;
    assign SysStrobe  = sys_stb_q;
    assign SysRW      = sys_rw_q;
    assign SysAddress = sys_addr_q;
    assign SysData_in = sys_wdata_q;
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: memory returns word = address; bus beats are logged and compared to hand-computed lists.
module tb_dcache_wb;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        PStrobe = 1'b0, PRw = 1'b1;
    logic [31:0] PAddress = '0, PData_out = '0;
    logic        PReady;
    logic [31:0] PData_in;
    logic        SysStrobe, SysRW;
    logic [31:0] SysAddress, SysData_in, SysData_out;
    logic        SysReady = 1'b1;

    int n_chk = 0;
    int n_pass = 0;

    logic        lg_rw[$];
    logic [31:0] lg_a[$];
    logic [31:0] lg_d[$];

    dcache_wb dut (
        .clock(clock), .reset(reset),
        .PStrobe(PStrobe), .PRw(PRw), .PAddress(PAddress),
        .PReady(PReady), .PData_in(PData_in), .PData_out(PData_out),
        .SysStrobe(SysStrobe), .SysRW(SysRW), .SysAddress(SysAddress),
        .SysData_in(SysData_in), .SysData_out(SysData_out), .SysReady(SysReady)
    );

    always #5 clock = ~clock;
    assign SysData_out = SysAddress;

    always @(negedge clock) begin
        #1;
        if (!reset && SysStrobe && SysReady) begin
            lg_rw.push_back(SysRW);
            lg_a.push_back(SysAddress);
            lg_d.push_back(SysData_in);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clr_log();
        lg_rw.delete();
        lg_a.delete();
        lg_d.delete();
    endtask

    task automatic chk_beat(input string tag, input int i, input logic rw,
                            input logic [31:0] a, input logic [31:0] d);
        if (i < lg_a.size()) begin
            chk({tag, "_rw"}, 32'(lg_rw[i]), 32'(rw));
            chk({tag, "_addr"}, lg_a[i], a);
            if (!rw) chk({tag, "_data"}, lg_d[i], d);
        end else begin
            chk({tag, "_count"}, 32'(lg_a.size()), 32'(i + 1));
        end
    endtask

    task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int cyc);
        clr_log();
        @(negedge clock);
        PStrobe = 1'b1; PRw = rw; PAddress = a; PData_out = wd;
        @(negedge clock);
        PStrobe = 1'b0; PAddress = '0; PData_out = '0;
        cyc = 1;
        while (!PReady && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("pready_seen", 32'(PReady), 32'd1);
        rd = PData_in;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wb_exp [4];
        int cyc;

        @(negedge clock);
        @(negedge clock);
        chk("rst_pready", 32'(PReady), 32'd0);
        chk("rst_sysstrobe", 32'(SysStrobe), 32'd0);
        chk("rst_sysrw", 32'(SysRW), 32'd1);
        chk("rst_sysaddr", SysAddress, 32'h0);
        chk("rst_sysdata", SysData_in, 32'h0);
        chk("rst_pdata", PData_in, 32'h0);
        reset = 1'b0;

        // Cold read miss: 4 read beats then data
        req(1'b1, 32'h100, '0, rd, cyc);
        chk("cold_data", rd, 32'h100);
        chk("cold_cycles", 32'(cyc), 32'd6);
        chk("cold_nbeats", 32'(lg_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_beat("cold_beat", i, 1'b1, 32'h100 + 32'(4 * i), '0);

        req(1'b1, 32'h108, '0, rd, cyc);
        chk("hit_data", rd, 32'h108);
        chk("hit_cycles", 32'(cyc), 32'd1);
        chk("hit_nbeats", 32'(lg_a.size()), 32'd0);

        req(1'b0, 32'h104, 32'hDEADBEEF, rd, cyc);
        chk("whit_cycles", 32'(cyc), 32'd1);
        chk("whit_nbeats", 32'(lg_a.size()), 32'd0);
        req(1'b1, 32'h104, '0, rd, cyc);
        chk("whit_readback", rd, 32'hDEADBEEF);

        // Dirty eviction of line 0x100 by 0x500
        req(1'b1, 32'h500, '0, rd, cyc);
        wb_exp = '{32'h100, 32'hDEADBEEF, 32'h108, 32'h10C};
        chk("evict_nbeats", 32'(lg_a.size()), 32'd8);
        for (int i = 0; i < 4; i++) chk_beat("evict_wb", i, 1'b0, 32'h100 + 32'(4 * i), wb_exp[i]);
        for (int i = 0; i < 4; i++) chk_beat("evict_rf", i + 4, 1'b1, 32'h500 + 32'(4 * i), '0);
        chk("evict_data", rd, 32'h500);
        chk("evict_cycles", 32'(cyc), 32'd10);

        // Write miss to a clean line, then hit, then eviction shows merged word
        req(1'b0, 32'h208, 32'h12345678, rd, cyc);
        chk("wmiss_nbeats", 32'(lg_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_beat("wmiss_rf", i, 1'b1, 32'h200 + 32'(4 * i), '0);
        req(1'b1, 32'h208, '0, rd, cyc);
        chk("wmiss_readback", rd, 32'h12345678);
        chk("wmiss_hit_cycles", 32'(cyc), 32'd1);
        req(1'b1, 32'h608, '0, rd, cyc);
        wb_exp = '{32'h200, 32'h204, 32'h12345678, 32'h20C};
        chk("wmiss_evict_nbeats", 32'(lg_a.size()), 32'd8);
        for (int i = 0; i < 4; i++) chk_beat("wmiss_wb", i, 1'b0, 32'h200 + 32'(4 * i), wb_exp[i]);
        chk("wmiss_evict_data", rd, 32'h608);

        // Back-to-back hits with PStrobe held high
        req(1'b1, 32'h100, '0, rd, cyc);
        chk("prime_data", rd, 32'h100);
        clr_log();
        @(negedge clock);
        PStrobe = 1'b1; PRw = 1'b1; PAddress = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("b2b_pready", 32'(PReady), 32'd1);
            chk("b2b_data", PData_in, 32'h100 + 32'(4 * i));
            PAddress = 32'h104 + 32'(4 * i);
            if (i == 2) PStrobe = 1'b0;
            @(negedge clock);
            chk("b2b_gap", 32'(PReady), 32'd0);
        end
        chk("b2b_nbeats", 32'(lg_a.size()), 32'd0);

        // Stall on refill beat 1, then reset mid-burst
        clr_log();
        @(negedge clock);
        PStrobe = 1'b1; PRw = 1'b1; PAddress = 32'h300;
        @(negedge clock);
        PStrobe = 1'b0;
        @(negedge clock);
        chk("stall_b0_addr", SysAddress, 32'h300);
        @(negedge clock);
        SysReady = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clock);
            chk("stall_strobe", 32'(SysStrobe), 32'd1);
            chk("stall_addr", SysAddress, 32'h304);
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_strobe", 32'(SysStrobe), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        SysReady = 1'b1;
        chk("rst_mid_pready", 32'(PReady), 32'd0);
        req(1'b1, 32'h300, '0, rd, cyc);
        chk("rerefill_nbeats", 32'(lg_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_beat("rerefill", i, 1'b1, 32'h300 + 32'(4 * i), '0);
        chk("rerefill_data", rd, 32'h300);
        chk("rerefill_cycles", 32'(cyc), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
